// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the destination-tag pipeline.
//                dest_tag_t is the per-stage record of an in-flight register
//                write: destination register, write enable and load flag.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } dest_tag_t;

    // A bubble carries no write and no load, so it can never match a
    // consumer in the hazard or forwarding compares.
    localparam dest_tag_t BUBBLE_TAG = '0;

    // Build the tag captured at ID->EX. Writes to register 0 are dropped
    // here so nothing downstream has to special-case the zero register.
    function automatic dest_tag_t normalise_tag(
        input logic                  valid,
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  reg_write,
        input logic                  mem_read
    );
        dest_tag_t t;
        t.rd        = rd;
        t.reg_write = valid & reg_write & (rd != '0);
        t.mem_read  = valid & mem_read;
        return t;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/tag_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tag_stage_reg
//  Description : One pipeline register holding a dest_tag_t. Priority is
//                reset, then hold, then bubble insertion, then load.
//  Ports       : clk          - core clock
//                rst          - synchronous active-high reset (clears tag)
//                hold         - keep the current tag
//                load_bubble  - load BUBBLE_TAG instead of d
//                d            - incoming tag
//                q            - registered tag
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_stage_reg
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      load_bubble,
    input  dest_tag_t d,
    output dest_tag_t q
);

    dest_tag_t r_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= BUBBLE_TAG;
        end else if (hold) begin
            r_tag <= r_tag;
        end else if (load_bubble) begin
            r_tag <= BUBBLE_TAG;
        end else begin
            r_tag <= d;
        end
    end

    assign q = r_tag;

endmodule : tag_stage_reg
`default_nettype wire

// File: rtl/dest_tag_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dest_tag_pipe
//  Description : Carries destination-register tags from ID through the EX,
//                MEM and WB pipeline registers, presents the EX/MEM tags to
//                the forwarding selects and detects load-use hazards.
//  Config      : HAZARD_STATS_EN - when defined, adds saturating
//                stall_cycles / bubble_count statistics outputs.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                id_valid, id_rs, id_rt   - ID instruction and its sources
//                id_uses_rt               - ID instruction reads rt
//                id_rd, id_reg_write,
//                id_mem_read              - ID destination tag fields
//                flush                    - kill the instruction entering EX
//                mem_busy                 - freeze EX/MEM/WB
//                stall                    - hold PC and IF/ID
//                ex_rd, ex_reg_write,
//                ex_mem_read              - EX-stage tag
//                mem_rd, mem_reg_write    - MEM-stage tag
//                wb_rd, wb_reg_write      - WB-stage tag (regfile write port)
//                stall_cycles,
//                bubble_count             - statistics (HAZARD_STATS_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module dest_tag_pipe #(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  mem_busy,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      bubble_count
`endif
);

    import pipe_pkg::*;

    dest_tag_t w_id_tag;
    dest_tag_t w_ex_tag;
    dest_tag_t w_mem_tag;
    dest_tag_t w_wb_tag;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_lu_stall;
    logic w_ex_bubble;

    // ------------------------------------------------------------------
    // ID tag normalisation
    // ------------------------------------------------------------------
    assign w_id_tag = normalise_tag(id_valid, id_rd, id_reg_write, id_mem_read);

    // ------------------------------------------------------------------
    // Load-use detect. Only the EX stage matters: one cycle later the load
    // sits in MEM and its data reaches the consumer via MEM->EX forwarding.
    // The compare uses registered EX state, so it has no path from the
    // stage registers' own next-state logic.
    // ------------------------------------------------------------------
    assign w_rs_hit   = (w_ex_tag.rd == id_rs);
    assign w_rt_hit   = id_uses_rt & (w_ex_tag.rd == id_rt);
    assign w_load_use = w_ex_tag.mem_read & w_ex_tag.reg_write & id_valid
                      & (w_rs_hit | w_rt_hit);

    // A flush kills the dependent instruction, so there is nothing to wait for.
    assign w_lu_stall  = w_load_use & ~flush;
    assign w_ex_bubble = flush | w_lu_stall;

    // During a freeze the front end must hold as well.
    assign stall = mem_busy | w_lu_stall;

    // ------------------------------------------------------------------
    // Stage registers. mem_busy holds every stage, which also keeps a
    // pending flush from taking effect until the freeze lifts.
    // ------------------------------------------------------------------
    tag_stage_reg u_ex_stage (
        .clk         (clk),
        .rst         (rst),
        .hold        (mem_busy),
        .load_bubble (w_ex_bubble),
        .d           (w_id_tag),
        .q           (w_ex_tag)
    );

    tag_stage_reg u_mem_stage (
        .clk         (clk),
        .rst         (rst),
        .hold        (mem_busy),
        .load_bubble (1'b0),
        .d           (w_ex_tag),
        .q           (w_mem_tag)
    );

    tag_stage_reg u_wb_stage (
        .clk         (clk),
        .rst         (rst),
        .hold        (mem_busy),
        .load_bubble (1'b0),
        .d           (w_mem_tag),
        .q           (w_wb_tag)
    );

    assign ex_rd         = w_ex_tag.rd;
    assign ex_reg_write  = w_ex_tag.reg_write;
    assign ex_mem_read   = w_ex_tag.mem_read;
    assign mem_rd        = w_mem_tag.rd;
    assign mem_reg_write = w_mem_tag.reg_write;
    assign wb_rd         = w_wb_tag.rd;
    assign wb_reg_write  = w_wb_tag.reg_write;

`ifdef HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Saturating hazard statistics
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_bubble_count;
    logic             w_bubble_loaded;

    // A bubble is only loaded on an edge where EX is not frozen.
    assign w_bubble_loaded = ~mem_busy & w_ex_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
        end else begin
            if (stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_bubble_loaded && (r_bubble_count != '1)) begin
                r_bubble_count <= r_bubble_count + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;
`endif

endmodule : dest_tag_pipe
`default_nettype wire

// File: tb/tb_dest_tag_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dest_tag_pipe
//  Description : Directed self-checking bench for dest_tag_pipe. A stage-array
//                model tracks the in-flight tags and is compared against the
//                DUT every negative edge; directed steps add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dest_tag_pipe;

    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rt;
    logic [AW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          flush;
    logic          mem_busy;
    logic          stall;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic [AW-1:0] mem_rd;
    logic          mem_reg_write;
    logic [AW-1:0] wb_rd;
    logic          wb_reg_write;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] bubble_count;
`endif

    always #5 clk = ~clk;

    dest_tag_pipe #(
        .REG_ADDR_W (AW)
`ifdef HAZARD_STATS_EN
        ,
        .CNT_W      (CW)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_rd         (id_rd),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .flush         (flush),
        .mem_busy      (mem_busy),
        .stall         (stall),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_count  (bubble_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: index 0 = EX, 1 = MEM, 2 = WB
    // ------------------------------------------------------------------
    logic [AW-1:0] m_rd [3];
    logic          m_rw [3];
    logic          m_mr [3];
    int unsigned   m_stall_cnt = 0;
    int unsigned   m_bub_cnt   = 0;
    bit            check_en    = 1'b0;

    function automatic logic model_stall();
        logic hit;
        hit = m_mr[0] && m_rw[0] && id_valid &&
              ((m_rd[0] == id_rs) || (id_uses_rt && (m_rd[0] == id_rt)));
        return mem_busy || (hit && !flush);
    endfunction

    always @(posedge clk) begin
        logic s;
        s = model_stall();
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_rd[i] = '0;
                m_rw[i] = 1'b0;
                m_mr[i] = 1'b0;
            end
            m_stall_cnt = 0;
            m_bub_cnt   = 0;
            check_en    = 1'b1;
        end else begin
            if (s && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (!mem_busy) begin
                for (int i = 2; i > 0; i--) begin
                    m_rd[i] = m_rd[i-1];
                    m_rw[i] = m_rw[i-1];
                    m_mr[i] = m_mr[i-1];
                end
                if (flush || s) begin
                    m_rd[0] = '0;
                    m_rw[0] = 1'b0;
                    m_mr[0] = 1'b0;
                    if (m_bub_cnt != 32'hFFFF_FFFF) m_bub_cnt++;
                end else begin
                    m_rd[0] = id_rd;
                    m_rw[0] = id_valid && id_reg_write && (id_rd != 0);
                    m_mr[0] = id_valid && id_mem_read;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("ex_rd",         ex_rd,         m_rd[0]);
            check("ex_reg_write",  ex_reg_write,  m_rw[0]);
            check("ex_mem_read",   ex_mem_read,   m_mr[0]);
            check("mem_rd",        mem_rd,        m_rd[1]);
            check("mem_reg_write", mem_reg_write, m_rw[1]);
            check("wb_rd",         wb_rd,         m_rd[2]);
            check("wb_reg_write",  wb_reg_write,  m_rw[2]);
            check("stall",         stall,         model_stall());
`ifdef HAZARD_STATS_EN
            check("stall_cycles",  stall_cycles,  m_stall_cnt);
            check("bubble_count",  bubble_count,  m_bub_cnt);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic urt, input logic [AW-1:0] rd, input logic rw, input logic mr);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef HAZARD_STATS_EN
        logic [CW-1:0] snap;
`endif
        rst      = 1'b1;
        flush    = 1'b0;
        mem_busy = 1'b0;
        drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1);

        // Reset with non-zero ID inputs
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst ex_rd",         ex_rd,         0);
        check("rst ex_reg_write",  ex_reg_write,  0);
        check("rst mem_reg_write", mem_reg_write, 0);
        check("rst wb_reg_write",  wb_reg_write,  0);
        check("rst stall",         stall,         0);
        idle();
        tick();

        // Back-to-back ALU ops rd=3 then rd=4
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        check("b2b ex_rd T+1", ex_rd, 3);
        check("b2b ex_rw T+1", ex_reg_write, 1);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        check("b2b ex_rd T+2",  ex_rd,  4);
        check("b2b mem_rd T+2", mem_rd, 3);
        idle();
        tick();
        check("b2b wb_rd T+3",  wb_rd, 3);
        check("b2b wb_rw T+3",  wb_reg_write, 1);
        check("b2b mem_rd T+3", mem_rd, 4);
        check("b2b stall",      stall, 0);

        // Load-use on rs
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd5, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        check("lu stall", stall, 1);
        tick();
        check("lu bubble ex_rw", ex_reg_write, 0);
        check("lu mem_rd",       mem_rd, 5);
        check("lu mem_rw",       mem_reg_write, 1);
        check("lu stall once",   stall, 0);
        tick();
        check("lu add ex_rd", ex_rd, 6);
        check("lu add ex_rw", ex_reg_write, 1);
        idle();
        tick();

        // Load-use on rt, gated by id_uses_rt
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd1, 5'd8, 1'b0, 5'd9, 1'b1, 1'b0);
        #1;
        check("rt unused stall", stall, 0);
        drive(1'b1, 5'd1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        check("rt used stall", stall, 1);
        idle();
        tick();

        // Load to register 0
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        check("r0 ex_rw", ex_reg_write, 0);
        check("r0 ex_mr", ex_mem_read, 1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        #1;
        check("r0 stall", stall, 0);
        tick();
        check("r0 consumer ex_rd", ex_rd, 2);
        check("r0 consumer ex_rw", ex_reg_write, 1);
        idle();
        tick();

        // Flush during load-use
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush stall", stall, 0);
        tick();
        check("flush ex_rw",  ex_reg_write, 0);
        check("flush ex_rd",  ex_rd, 0);
        check("flush mem_rd", mem_rd, 5);
        flush = 1'b0;
        idle();

        // mem_busy freeze with rd=7 in MEM, rd=12 in WB
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check("busy pre mem_rd", mem_rd, 7);
        check("busy pre wb_rd",  wb_rd, 12);
        mem_busy = 1'b1;
        #1;
        check("busy stall", stall, 1);
`ifdef HAZARD_STATS_EN
        snap = stall_cycles;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy mem_rd", mem_rd, 7);
            check("busy wb_rd",  wb_rd, 12);
            check("busy stall",  stall, 1);
        end
        mem_busy = 1'b0;
`ifdef HAZARD_STATS_EN
        check("busy stall_cycles delta", stall_cycles - snap, 3);
`endif
        tick();
        check("release wb_rd", wb_rd, 7);
        check("release wb_rw", wb_reg_write, 1);

        // Reset during a freeze discards in-flight tags
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        mem_busy = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        mem_busy = 1'b0;
        idle();
        #1;
        check("rst2 ex_rw",  ex_reg_write, 0);
        check("rst2 mem_rw", mem_reg_write, 0);
        check("rst2 wb_rd",  wb_rd, 0);
        check("rst2 wb_rw",  wb_reg_write, 0);
        check("rst2 stall",  stall, 0);
`ifdef HAZARD_STATS_EN
        check("rst2 stall_cycles", stall_cycles, 0);
        check("rst2 bubble_count", bubble_count, 0);
`endif
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dest_tag_pipe
`default_nettype wire
